// File: rtl/fifo_wr_ctrl.sv
// Write-domain control for an async FIFO: binary/Gray write pointer, read-pointer
// synchronizer, registered full flag, fill level and sticky overflow.
module fifo_wr_ctrl #(
   parameter int ADDR_W      = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w_inc,
   input  logic [ADDR_W:0]   rd_ptr_gray,
   output logic [ADDR_W-1:0] wraddress,
   output logic [ADDR_W:0]   wr_ptr_gray,
   output logic              wr_en,
   output logic              full,
   output logic [ADDR_W:0]   fill_level,
   output logic              overflow
);

   localparam int PTR_W = ADDR_W + 1;
   localparam int DEPTH = 1 << ADDR_W;

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("fifo_wr_ctrl: SYNC_STAGES must be at least 2");
   end
   if (ADDR_W < 2) begin : g_bad_addr
      $error("fifo_wr_ctrl: ADDR_W must be at least 2");
   end

   function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
      logic [ADDR_W:0] b;
      b[ADDR_W] = g[ADDR_W];
      for (int i = ADDR_W - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [ADDR_W:0] wr_bin;
   logic [ADDR_W:0] wr_bin_next;
   logic [ADDR_W:0] wr_gray_next;
   logic [ADDR_W:0] rq_sync;
   logic [ADDR_W:0] rq_bin;
   logic [ADDR_W:0] full_pattern;
   logic            full_next;
   logic [ADDR_W:0] sync_q [SYNC_STAGES];

   assign wr_en        = w_inc && !full;
   assign wr_bin_next  = wr_bin + PTR_W'(wr_en);
   assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
   assign wraddress    = wr_bin[ADDR_W-1:0];

   // Full when the next write pointer has lapped the synchronized read pointer
   // by exactly one depth: in Gray form that is the top two bits inverted.
   assign rq_sync      = sync_q[SYNC_STAGES-1];
   assign full_pattern = {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]};
   assign full_next    = (wr_gray_next == full_pattern);

   assign rq_bin       = gray2bin(rq_sync);
   assign fill_level   = wr_bin - rq_bin;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bin      <= '0;
         wr_ptr_gray <= '0;
         full        <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         wr_bin      <= wr_bin_next;
         wr_ptr_gray <= wr_gray_next;
         full        <= full_next;
         if (w_inc && full) begin
            overflow <= 1'b1;
         end
      end
   end

   // NOTE: the synchronizer flops are reset so a freshly reset FIFO reads as
   // empty; this chain is plain flops, not a memory array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= rd_ptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   a_gray_one_bit : assert property (@(posedge clk) disable iff (!rst_n)
      $countones(wr_ptr_gray ^ $past(wr_ptr_gray)) <= 1);

   a_fill_bound : assert property (@(posedge clk) disable iff (!rst_n)
      fill_level <= PTR_W'(DEPTH));

endmodule
